// File: rtl/lcd_refresh_driver.sv
// lcd_refresh_driver: HD44780 16x2 8-bit write-only init + continuous DDRAM refresh.
// Optional inter-frame idle period enabled by defining LCD_FRAME_GAP_EN.  Rev 1.0
`default_nettype none

module lcd_refresh_driver #(
    parameter int POWERUP_WAIT_CYC = 750000,
    parameter int E_PULSE_CYC      = 12,
    parameter int CMD_WAIT_CYC     = 2500,
    parameter int CLEAR_WAIT_CYC   = 100000,
    parameter int FRAME_GAP_CYC    = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam logic [23:0] PWR_LAST = 24'(POWERUP_WAIT_CYC - 1);
    localparam logic [23:0] E_LAST   = 24'(E_PULSE_CYC - 1);
    localparam logic [23:0] CMD_LAST = 24'(CMD_WAIT_CYC - 1);
    localparam logic [23:0] CLR_LAST = 24'(CLEAR_WAIT_CYC - 1);
    localparam logic [5:0]  STEP_CLR = 6'd3;
    localparam logic [5:0]  STEP_L1  = 6'd4;
    localparam logic [5:0]  STEP_END = 6'd37;

    if (POWERUP_WAIT_CYC < 1 || POWERUP_WAIT_CYC >= (1 << 24) ||
        E_PULSE_CYC < 1 || E_PULSE_CYC >= (1 << 24) ||
        CMD_WAIT_CYC < 1 || CMD_WAIT_CYC >= (1 << 24) ||
        CLEAR_WAIT_CYC < 1 || CLEAR_WAIT_CYC >= (1 << 24) ||
        FRAME_GAP_CYC < 1 || FRAME_GAP_CYC >= (1 << 24)) begin : g_param_check
        $error("lcd_refresh_driver: timing parameters must lie in 1 .. 2^24-1");
    end

`ifdef LCD_FRAME_GAP_EN
    localparam logic [23:0] GAP_LAST = 24'(FRAME_GAP_CYC - 1);
`endif

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        FETCH    = 3'd1,
        SETUP    = 3'd2,
        E_HI     = 3'd3,
        HOLD     = 3'd4
`ifdef LCD_FRAME_GAP_EN
        , GAP    = 3'd5
`endif
    } state_t;

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic [5:0]  step, step_n;
    logic [4:0]  index_n;
    logic [7:0]  data_n;
    logic        rs_n, init_n, frame_n, cnt_zero;

    // Steps 5-20 and 22-37 are character writes; all others are commands.
    function automatic logic is_char(input logic [5:0] s);
        return ((s >= 6'd5) && (s <= 6'd20)) || ((s >= 6'd22) && (s <= 6'd37));
    endfunction

    function automatic logic [4:0] char_pos(input logic [5:0] s);
        return (s <= 6'd20) ? 5'(s - 6'd5) : 5'(s - 6'd6);
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [5:0] s);
        case (s)
            6'd0:    return 8'h38;
            6'd1:    return 8'h0C;
            6'd2:    return 8'h06;
            6'd3:    return 8'h01;
            6'd4:    return 8'h80;
            6'd21:   return 8'hC0;
            default: return 8'h00;
        endcase
    endfunction

    assign lcd_rw   = 1'b0;
    assign cnt_zero = (cnt == 24'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PWR_WAIT;
            cnt        <= '0;
            step       <= '0;
            index      <= '0;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_data   <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            step       <= step_n;
            index      <= index_n;
            lcd_rs     <= rs_n;
            lcd_e      <= (state_n == E_HI);
            lcd_data   <= data_n;
            init_done  <= init_n;
            frame_done <= frame_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        step_n  = step;
        index_n = index;
        data_n  = lcd_data;
        rs_n    = lcd_rs;
        init_n  = init_done;
        frame_n = 1'b0;
        case (state)
            // Counts up from the cleared reset value so the wait starts on edge 1.
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_n = SETUP;
                    data_n  = cmd_byte(step);
                    rs_n    = 1'b0;
                end else begin
                    cnt_n = cnt + 24'd1;
                end
            end
            FETCH: begin
                if (cnt_zero) begin
                    state_n = SETUP;
                    data_n  = char_in;
                    rs_n    = 1'b1;
                end else begin
                    cnt_n = cnt - 24'd1;
                end
            end
            SETUP: begin
                state_n = E_HI;
                cnt_n   = E_LAST;
            end
            E_HI: begin
                if (cnt_zero) begin
                    state_n = HOLD;
                    cnt_n   = (step == STEP_CLR) ? CLR_LAST : CMD_LAST;
                end else begin
                    cnt_n = cnt - 24'd1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    if (step == STEP_CLR) init_n = 1'b1;
                    frame_n = (step == STEP_END);
                    step_n  = (step == STEP_END) ? STEP_L1 : step + 6'd1;
`ifdef LCD_FRAME_GAP_EN
                    if (step == STEP_END) begin
                        state_n = GAP;
                        cnt_n   = GAP_LAST;
                    end else
`endif
                    if (is_char(step_n)) begin
                        state_n = FETCH;
                        index_n = char_pos(step_n);
                        cnt_n   = 24'd1;
                    end else begin
                        state_n = SETUP;
                        data_n  = cmd_byte(step_n);
                        rs_n    = 1'b0;
                    end
                end else begin
                    cnt_n = cnt - 24'd1;
                end
            end
`ifdef LCD_FRAME_GAP_EN
            GAP: begin
                if (cnt_zero) begin
                    state_n = SETUP;
                    data_n  = cmd_byte(STEP_L1);
                    rs_n    = 1'b0;
                end else begin
                    cnt_n = cnt - 24'd1;
                end
            end
`endif
            default: state_n = PWR_WAIT;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_refresh_driver.sv
// tb_lcd_refresh_driver: scoreboard bench for lcd_refresh_driver (gap feature off).
`default_nettype none

module tb_lcd_refresh_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_in = 8'h41;
    logic [4:0] index;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
    logic [7:0] lcd_data;

    lcd_refresh_driver #(
        .POWERUP_WAIT_CYC(100),
        .E_PULSE_CYC     (4),
        .CMD_WAIT_CYC    (10),
        .CLEAR_WAIT_CYC  (50),
        .FRAME_GAP_CYC   (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .char_in   (char_in),
        .index     (index),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Character source: one cycle of 0xFF after an index change, then 0x41+index.
    logic [4:0] last_idx = 5'd0;
    always @(negedge clk) begin
        if (index != last_idx) char_in = 8'hFF;
        else                   char_in = 8'h41 + {3'd0, index};
        last_idx = index;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [8:0] exp_q[$];

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_frame();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(8'h41 + i)});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, 8'(8'h41 + i)});
    endtask

    int         cyc, rise_cyc, fall_cyc, fd_cyc, n_rises, frame_cnt;
    logic       e_prev, id_prev, fd_prev, prev_rs;
    logic [7:0] prev_data;
    logic [8:0] cur_byte, last_byte;

    task automatic mon_reset();
        cyc = 0; rise_cyc = 0; fall_cyc = 0; fd_cyc = 0; n_rises = 0; frame_cnt = 0;
        e_prev = 1'b0; id_prev = 1'b0; fd_prev = 1'b0; prev_rs = 1'b0; prev_data = 8'h00;
        cur_byte = 9'h0; last_byte = 9'h0;
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, "_e"}, {31'd0, lcd_e}, 0);
        check_value({tag, "_data"}, {24'd0, lcd_data}, 0);
        check_value({tag, "_index"}, {27'd0, index}, 0);
        check_value({tag, "_rs"}, {31'd0, lcd_rs}, 0);
        check_value({tag, "_init"}, {31'd0, init_done}, 0);
        check_value({tag, "_fd"}, {31'd0, frame_done}, 0);
    endtask

    // Called once per falling edge; cyc equals the number of rising edges since release.
    task automatic mon_step();
        logic [8:0] exp;
        if (cyc == 100) begin
            check_value("pwr_quiet_e", {31'd0, lcd_e}, 0);
            check_value("pwr_init_low", {31'd0, init_done}, 0);
        end
        if (lcd_e && !e_prev) begin
            if (n_rises == 0)      check_value("first_e_rise", cyc, 101);
            else if (n_rises < 4)  check_value("init_spacing", cyc - rise_cyc, 15);
            if (n_rises == 4)      check_value("clear_wait", cyc - fall_cyc, 51);
            check_value("setup_stable", {23'd0, prev_rs, prev_data}, {23'd0, lcd_rs, lcd_data});
            check_value("rw_low", {31'd0, lcd_rw}, 0);
            if (exp_q.size() == 0) begin
                check_value("sb_underflow", exp_q.size(), 1);
            end else begin
                exp = exp_q.pop_front();
                check_value("byte", {23'd0, lcd_rs, lcd_data}, {23'd0, exp});
            end
            if (lcd_rs) check_value("no_ff_write", {31'd0, lcd_data == 8'hFF}, 0);
            rise_cyc = cyc;
            n_rises++;
            cur_byte = {lcd_rs, lcd_data};
        end
        if (!lcd_e && e_prev) begin
            check_value("e_width", cyc - rise_cyc, 4);
            fall_cyc  = cyc;
            last_byte = cur_byte;
        end
        if (init_done && !id_prev) begin
            check_value("init_after_clear", {23'd0, last_byte}, 32'h001);
            check_value("init_done_time", cyc - fall_cyc, 50);
        end
        if (frame_done) begin
            check_value("fd_one_cycle", {31'd0, fd_prev}, 0);
            check_value("fd_after_c31", {23'd0, last_byte}, 32'h160);
            check_value("fd_time", cyc - fall_cyc, 10);
            if (frame_cnt > 0) check_value("frame_period", cyc - fd_cyc, 574);
            fd_cyc = cyc;
            frame_cnt++;
        end
        e_prev    = lcd_e;
        id_prev   = init_done;
        fd_prev   = frame_done;
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
    endtask

    initial begin
        logic hit;
        mon_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        push_init();
        push_frame(); push_frame(); push_frame();
        rst = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            cyc++;
            mon_step();
            if (frame_cnt == 2 && lcd_e && lcd_rs && lcd_data == 8'h48) hit = 1'b1;
        end
        check_value("reach_char7_f3", {31'd0, hit}, 1);

        // Asynchronous reset while lcd_e is high mid-character.
        #1 rst = 1'b0;
        #1 check_reset_state("midreset");
        repeat (3) @(negedge clk);
        exp_q.delete();
        mon_reset();
        push_init();
        push_frame();
        rst = 1'b1;
        for (int i = 0; i < 2000 && frame_cnt == 0; i++) begin
            @(negedge clk);
            cyc++;
            mon_step();
        end
        check_value("refresh_frame_done", frame_cnt, 1);
        check_value("rise_count_after_rst", n_rises, 38);
        check_value("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
